// File: rtl/data_memory_arbiter_if.sv
// -----------------------------------------------------------------------------
// data_memory_arbiter_if
// Bundles every signal between the two requesters, the arbiter and the
// 256x8 data memory.
//   m0_* : core load/store path (req/we/adr/wdata in, ack/rdata back)
//   m1_* : DMA / test port, same shape as m0_*
//   mem_*: memory pins (adr, datain, w, r driven by the arbiter; dataout back)
//   busy : arbiter is inside a transaction
// Modports:
//   slave  - the arbiter's view
//   master - the view of the requesters plus the memory (the environment)
// -----------------------------------------------------------------------------
interface data_memory_arbiter_if #(
    parameter int AW = 8,
    parameter int DW = 8
);
    logic          m0_req;
    logic          m0_we;
    logic [AW-1:0] m0_adr;
    logic [DW-1:0] m0_wdata;
    logic          m0_ack;
    logic [DW-1:0] m0_rdata;

    logic          m1_req;
    logic          m1_we;
    logic [AW-1:0] m1_adr;
    logic [DW-1:0] m1_wdata;
    logic          m1_ack;
    logic [DW-1:0] m1_rdata;

    logic [AW-1:0] mem_adr;
    logic [DW-1:0] mem_datain;
    logic          mem_w;
    logic          mem_r;
    logic [DW-1:0] mem_dataout;

    logic          busy;

    modport slave (
        input  m0_req, m0_we, m0_adr, m0_wdata,
        output m0_ack, m0_rdata,
        input  m1_req, m1_we, m1_adr, m1_wdata,
        output m1_ack, m1_rdata,
        output mem_adr, mem_datain, mem_w, mem_r,
        input  mem_dataout,
        output busy
    );

    modport master (
        output m0_req, m0_we, m0_adr, m0_wdata,
        input  m0_ack, m0_rdata,
        output m1_req, m1_we, m1_adr, m1_wdata,
        input  m1_ack, m1_rdata,
        input  mem_adr, mem_datain, mem_w, mem_r,
        output mem_dataout,
        input  busy
    );
endinterface

// File: rtl/data_memory_arbiter.sv
// -----------------------------------------------------------------------------
// data_memory_arbiter
// Two-master round-robin arbiter and access sequencer for a single-port
// data memory with synchronous write and combinational read.
// Each transaction runs IDLE -> ACCESS -> DONE (one transaction per 3 cycles):
// the winning request is latched on the IDLE edge, driven onto the memory for
// exactly one ACCESS cycle, and acknowledged for one cycle in DONE with the
// read data already registered.
// Ports:
//   clk  - system clock, all state on the rising edge
//   rst  - asynchronous active-high reset
//   bus  - data_memory_arbiter_if.slave (requester handshakes + memory pins)
// -----------------------------------------------------------------------------
module data_memory_arbiter #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    data_memory_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t        state_q, state_d;

    // Latched transaction; these registers also drive mem_adr/mem_datain so
    // the memory pins hold their last values between accesses.
    logic          sel_q;
    logic          we_q;
    logic [AW-1:0] adr_q;
    logic [DW-1:0] wdata_q;
    logic          last_grant_q;

    logic [1:0]    req_vec;
    logic          sel_d;
    logic          we_d;
    logic [AW-1:0] adr_d;
    logic [DW-1:0] wdata_d;
    logic          latch_en;

    logic          mem_w;
    logic          mem_r;
    logic          busy;
    logic [1:0]    ack_vec;

    assign req_vec = {bus.m1_req, bus.m0_req};

    // Lone requester wins outright; on a tie the master that was not granted
    // last time goes first.
    assign sel_d   = (req_vec == 2'b11) ? ~last_grant_q : req_vec[1];
    assign we_d    = sel_d ? bus.m1_we    : bus.m0_we;
    assign adr_d   = sel_d ? bus.m1_adr   : bus.m0_adr;
    assign wdata_d = sel_d ? bus.m1_wdata : bus.m0_wdata;

    assign latch_en = (state_q == IDLE) && (|req_vec);

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (|req_vec) state_d = ACCESS;
            ACCESS:  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Strobes are decoded from the state register alone, so the asynchronous
    // reset pulls mem_w low the instant rst rises and no write can commit.
    always_comb begin
        mem_w   = 1'b0;
        mem_r   = 1'b0;
        ack_vec = 2'b00;
        busy    = (state_q != IDLE);
        case (state_q)
            ACCESS: begin
                mem_w = we_q;
                mem_r = ~we_q;
            end
            DONE: begin
                ack_vec[sel_q] = 1'b1;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------- request latch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_q        <= 1'b0;
            we_q         <= 1'b0;
            adr_q        <= '0;
            wdata_q      <= '0;
            last_grant_q <= 1'b1;   // m0 wins the first tie after reset
        end else begin
            if (latch_en) begin
                sel_q   <= sel_d;
                we_q    <= we_d;
                adr_q   <= adr_d;
                wdata_q <= wdata_d;
            end
            if (state_q == ACCESS) begin
                last_grant_q <= sel_q;
            end
        end
    end

    // ------------------------------------------------- per-master read data
    // Each master keeps its own read register; it only moves when that
    // master's own read closes ACCESS, so writes and the other master's reads
    // leave it untouched.
    for (genvar gi = 0; gi < 2; gi++) begin : g_master
        logic [DW-1:0] rdata_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rdata_q <= '0;
            end else if ((state_q == ACCESS) && !we_q && (sel_q == 1'(gi))) begin
                rdata_q <= bus.mem_dataout;
            end
        end
    end

    // ------------------------------------------------------------ outputs
    assign bus.m0_ack     = ack_vec[0];
    assign bus.m1_ack     = ack_vec[1];
    assign bus.m0_rdata   = g_master[0].rdata_q;
    assign bus.m1_rdata   = g_master[1].rdata_q;
    assign bus.mem_adr    = adr_q;
    assign bus.mem_datain = wdata_q;
    assign bus.mem_w      = mem_w;
    assign bus.mem_r      = mem_r;
    assign bus.busy       = busy;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// -----------------------------------------------------------------------------
// tb_data_memory_arbiter
// Directed bench for data_memory_arbiter with a behavioural 256x8 memory
// (MEMO[i]=i at start). Stimulus pushes the expected read data per master
// (and, where the grant order is known, the expected master order) into
// queues; a negedge monitor pops and compares on every ack.
// -----------------------------------------------------------------------------
module tb_data_memory_arbiter;

    logic clk;
    logic rst;

    data_memory_arbiter_if #(.AW(8), .DW(8)) bus ();

    data_memory_arbiter #(.AW(8), .DW(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------ memory model
    logic [7:0] memo [256];
    bit         mem_ready = 1'b0;

    // 0xEE stands in for the floating bus, so any sample taken outside a
    // read shows up as wrong data.
    assign bus.mem_dataout = bus.mem_r ? memo[bus.mem_adr] : 8'hEE;

    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 256; i++) memo[i] <= 8'(i);
            mem_ready <= 1'b1;
        end else if (bus.mem_w) begin
            memo[bus.mem_adr] <= bus.mem_datain;
        end
    end

    // ------------------------------------------------------- scoreboard
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] exp_q0 [$];
    logic [7:0] exp_q1 [$];
    int         order_q [$];

    int cyc        = 0;
    int ack_cnt[2] = '{0, 0};
    int ack_cyc[2] = '{0, 0};
    int prev_ack   = -1;
    bit spacing_on = 1'b0;
    int wcount     = 0;
    int rcount     = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    function automatic logic get_ack(input int m);
        return (m == 0) ? bus.m0_ack : bus.m1_ack;
    endfunction

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (!rst) begin
            if (bus.mem_w) wcount = wcount + 1;
            if (bus.mem_r) rcount = rcount + 1;
            if (bus.m0_ack || bus.m1_ack)
                chk("one_hot_ack", 32'(bus.m0_ack & bus.m1_ack), 32'd0);
            for (int m = 0; m < 2; m++) begin
                if (get_ack(m)) begin
                    logic [7:0] rd;
                    int         qsz;
                    rd  = (m == 0) ? bus.m0_rdata : bus.m1_rdata;
                    qsz = (m == 0) ? exp_q0.size() : exp_q1.size();
                    ack_cnt[m] = ack_cnt[m] + 1;
                    ack_cyc[m] = cyc;
                    if (qsz == 0) begin
                        chk($sformatf("unexpected_ack_m%0d", m), 32'(get_ack(m)), 32'd0);
                    end else begin
                        logic [7:0] e;
                        e = (m == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                        chk($sformatf("rdata_m%0d", m), 32'(rd), 32'(e));
                    end
                    if (order_q.size() != 0)
                        chk("grant_order", 32'(m), 32'(order_q.pop_front()));
                    if (spacing_on && prev_ack >= 0)
                        chk("ack_spacing", 32'(cyc - prev_ack), 32'd3);
                    prev_ack = cyc;
                end
            end
        end
    end

    // ----------------------------------------------------------- drivers
    task automatic set_req(input int m, input logic req, input logic we,
                           input logic [7:0] adr, input logic [7:0] wdata);
        if (m == 0) begin
            bus.m0_req = req; bus.m0_we = we; bus.m0_adr = adr; bus.m0_wdata = wdata;
        end else begin
            bus.m1_req = req; bus.m1_we = we; bus.m1_adr = adr; bus.m1_wdata = wdata;
        end
    endtask

    task automatic drop(input int m);
        if (m == 0) bus.m0_req = 1'b0;
        else        bus.m1_req = 1'b0;
    endtask

    // Called at posedge+1; returns at posedge+1 after the ack cycle with req
    // still high so the caller can chain a back-to-back request or drop it.
    task automatic txn(input int m, input logic we, input logic [7:0] adr,
                       input logic [7:0] wdata, input logic [7:0] exp_rdata);
        bit got;
        if (m == 0) exp_q0.push_back(exp_rdata);
        else        exp_q1.push_back(exp_rdata);
        set_req(m, 1'b1, we, adr, wdata);
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            got = get_ack(m);
        end
        if (!got) chk($sformatf("ack_timeout_m%0d", m), 32'(got), 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        set_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
        set_req(1, 1'b0, 1'b0, 8'h00, 8'h00);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        prev_ack = -1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // --------------------------------------------------------- stimulus
    initial begin
        int a0, a1, w0;

        rst = 1'b1;
        set_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
        set_req(1, 1'b0, 1'b0, 8'h00, 8'h00);
        do_reset();

        // Reset state
        @(negedge clk);
        chk("rst_busy",    32'(bus.busy),       32'd0);
        chk("rst_mem_w",   32'(bus.mem_w),      32'd0);
        chk("rst_mem_r",   32'(bus.mem_r),      32'd0);
        chk("rst_mem_adr", 32'(bus.mem_adr),    32'd0);
        chk("rst_datain",  32'(bus.mem_datain), 32'd0);
        chk("rst_m0_rd",   32'(bus.m0_rdata),   32'd0);
        chk("rst_m1_rd",   32'(bus.m1_rdata),   32'd0);

        // T1: m0 read 0x2A, cycle-accurate latency
        @(posedge clk); #1;
        a1 = ack_cnt[1];
        exp_q0.push_back(8'h2A);
        set_req(0, 1'b1, 1'b0, 8'h2A, 8'h00);
        @(negedge clk);                          // still IDLE, req sampled next edge
        chk("t1_idle_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);                          // ACCESS
        chk("t1_acc_mem_r",  32'(bus.mem_r),   32'd1);
        chk("t1_acc_mem_w",  32'(bus.mem_w),   32'd0);
        chk("t1_acc_adr",    32'(bus.mem_adr), 32'h2A);
        chk("t1_acc_ack",    32'(bus.m0_ack),  32'd0);
        @(negedge clk);                          // DONE
        chk("t1_done_ack",   32'(bus.m0_ack),  32'd1);
        chk("t1_done_mem_r", 32'(bus.mem_r),   32'd0);
        chk("t1_done_busy",  32'(bus.busy),    32'd1);
        chk("t1_hold_adr",   32'(bus.mem_adr), 32'h2A);
        @(posedge clk); #1;
        drop(0);
        @(negedge clk);
        chk("t1_after_ack",  32'(bus.m0_ack),  32'd0);
        chk("t1_after_busy", 32'(bus.busy),    32'd0);
        chk("t1_m1_no_ack",  32'(ack_cnt[1] - a1), 32'd0);

        // T2: m1 write 0x10=0xA5 then read it back
        do_reset();
        w0 = wcount;
        txn(1, 1'b1, 8'h10, 8'hA5, 8'h00);      // write leaves m1_rdata at 0
        drop(1);
        chk("t2_one_write", 32'(wcount - w0), 32'd1);
        chk("t2_memo10",    32'(memo[8'h10]), 32'hA5);
        txn(1, 1'b0, 8'h10, 8'h00, 8'hA5);
        drop(1);
        chk("t2_m0_rdata",  32'(bus.m0_rdata), 32'd0);

        // T3: simultaneous requests after reset, m0 first
        do_reset();
        order_q.push_back(0);
        order_q.push_back(1);
        fork
            begin txn(0, 1'b0, 8'h01, 8'h00, 8'h01); drop(0); end
            begin txn(1, 1'b0, 8'h02, 8'h00, 8'h02); drop(1); end
        join
        chk("t3_ack_gap", 32'(ack_cyc[1] - ack_cyc[0]), 32'd3);

        // T4: both hold req for 6 transactions -> strict alternation
        do_reset();
        for (int k = 0; k < 3; k++) begin
            order_q.push_back(0);
            order_q.push_back(1);
        end
        spacing_on = 1'b1;
        fork
            begin
                for (int k = 0; k < 3; k++) txn(0, 1'b0, 8'(8'h30 + k), 8'h00, 8'(8'h30 + k));
                drop(0);
            end
            begin
                for (int k = 0; k < 3; k++) txn(1, 1'b0, 8'(8'h40 + k), 8'h00, 8'(8'h40 + k));
                drop(1);
            end
        join
        spacing_on = 1'b0;
        chk("t4_order_drained", 32'(order_q.size()), 32'd0);

        // T5: reset during ACCESS of an m0 write
        do_reset();
        a0 = ack_cnt[0];
        set_req(0, 1'b1, 1'b1, 8'h05, 8'hFF);
        @(posedge clk); #1;                      // now in ACCESS
        chk("t5_access_w", 32'(bus.mem_w), 32'd1);
        rst = 1'b1;
        #1;
        chk("t5_rst_mem_w",  32'(bus.mem_w),      32'd0);
        chk("t5_rst_busy",   32'(bus.busy),       32'd0);
        chk("t5_rst_adr",    32'(bus.mem_adr),    32'd0);
        chk("t5_rst_datain", 32'(bus.mem_datain), 32'd0);
        drop(0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("t5_memo05", 32'(memo[8'h05]), 32'h05);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("t5_no_ack", 32'(ack_cnt[0] - a0), 32'd0);

        // T6: m1 read 0xFE, req withdrawn during ACCESS
        do_reset();
        a1 = ack_cnt[1];
        exp_q1.push_back(8'hFE);
        set_req(1, 1'b1, 1'b0, 8'hFE, 8'h00);
        @(posedge clk); #1;                      // ACCESS
        chk("t6_access_r", 32'(bus.mem_r), 32'd1);
        drop(1);
        repeat (8) @(negedge clk);
        chk("t6_one_ack",  32'(ack_cnt[1] - a1), 32'd1);
        chk("t6_m1_rdata", 32'(bus.m1_rdata),    32'hFE);
        chk("t6_idle",     32'(bus.busy),        32'd0);

        chk("exp_q0_drained", 32'(exp_q0.size()), 32'd0);
        chk("exp_q1_drained", 32'(exp_q1.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/data_memory_arbiter.md
Name: data_memory_arbiter

Overview:
Two-master round-robin arbiter and access sequencer for the 256x8 single-port data memory (synchronous write, combinational tri-stated read).
- Two requesters share the memory: m0 is the core load/store path and m1 is the DMA/test port.
- Each request is latched, presented to the memory for exactly one ACCESS cycle, and completed with a one-cycle ack plus registered read data.
- Sits between the requesters and the memory's adr/datain/w/r/dataout pins.

Parameters:
AW, 8, address width; memory depth is 2**AW.
DW, 8, data width.

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous active-high reset
m0_req  input  1  master 0 request; held until m0_ack
m0_we  input  1  master 0: 1=write, 0=read
m0_adr  input  AW  master 0 address
m0_wdata  input  DW  master 0 write data
m0_ack  output  1  master 0 completion pulse (1 cycle)
m0_rdata  output  DW  master 0 read data, registered
m1_req, m1_we, m1_adr, m1_wdata, m1_ack, m1_rdata  same as m0_* for master 1
mem_adr  output  AW  to memory adr
mem_datain  output  DW  to memory datain
mem_w  output  1  to memory w
mem_r  output  1  to memory r
mem_dataout  input  DW  from memory dataout (Z when mem_r=0)
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset values (async on rst=1):
  - state=IDLE; last_grant=1, so m0 wins the first tie.
  - mem_w=0, mem_r=0, mem_adr=0, mem_datain=0.
  - m0_ack=m1_ack=0, m0_rdata=m1_rdata=0, busy=0.
- FSM states: IDLE -> ACCESS -> DONE -> IDLE.
- IDLE transition:
  - If any req=1 at the clock edge, select sel: the only requester, or on a tie the one != last_grant.
  - Latch sel, we, adr, wdata into internal registers and go to ACCESS.
  - If no req, stay in IDLE.
- ACCESS (exactly 1 cycle):
  - mem_adr = latched adr; mem_datain = latched wdata.
  - mem_w = latched we; mem_r = !latched we.
  - At the closing edge: for a read, capture mem_dataout into m<sel>_rdata; for a write, the memory commits on this same edge.
  - Then set m<sel>_ack=1, last_grant=sel, go to DONE.
- DONE (1 cycle):
  - m<sel>_ack=1; mem_w=0, mem_r=0.
  - Next state is IDLE; ack clears.
- Latency: req sampled at edge N -> ACCESS in cycle N+1 -> ack and rdata valid in cycle N+2. Throughput is one transaction per 3 cycles.
- Outside ACCESS:
  - mem_w=0 and mem_r=0 always; mem_dataout is never sampled.
  - mem_adr and mem_datain hold their last values.
- mN_rdata holds its value until that master's next read completes. Writes and the other master's reads do not change it.
- Handshake rules:
  - A requester holds req/we/adr/wdata stable until it sees ack, and drops req on the edge ending the ack cycle.
  - A req still high in the IDLE cycle after DONE is treated as a new request (back-to-back).
  - Request fields that change after the IDLE latch edge are ignored for the in-flight transaction.
- Req withdrawn after being latched: the transaction still completes and acks.
- The non-selected requester waits with no ack. Round-robin guarantees it is served next, so worst-case wait is 6 cycles.
- Only one ack is ever high per cycle; m0_ack and m1_ack are never both 1.
- Reset mid-operation: asserting rst during ACCESS forces mem_w=0 immediately, so no write commits on any edge while rst=1. The pending ack is discarded. After release, the FSM is in IDLE with m0 preferred.
- Address is AW bits wide, with no wrap or overflow logic; 0xFF is a normal address.

Test Plan:
- Reset, then m0 read adr=0x2A (memory initialised MEMO[i]=i) -> mem_r=1 for one cycle at 0x2A; m0_ack pulses 2 cycles after req sampled; m0_rdata=0x2A; m1_ack stays 0.
- m1 write adr=0x10 data=0xA5, then m1 read 0x10 -> mem_w=1 for one cycle; m1_ack; the subsequent read gives m1_rdata=0xA5; m0_rdata unchanged at 0.
- m0 and m1 request simultaneously after reset (m0 read 0x01, m1 read 0x02) -> m0 served first (m0_rdata=0x01), m1 next (m1_rdata=0x02); acks 3 cycles apart.
- Both hold req continuously for 6 transactions -> grants alternate m0,m1,m0,m1,...; never two consecutive grants to one master while the other waits; busy low one cycle between transactions.
- rst asserted during ACCESS of m0 write adr=0x05 data=0xFF -> mem_w drops immediately; MEMO[0x05] stays 0x05; no ack; all outputs return to reset values.
- m1 drops req in the ACCESS cycle of its read of 0xFE -> transaction completes; m1_ack=1; m1_rdata=0xFE; no further grant to m1.
